// File: rtl/calc_operand_sequencer.sv
// calc_operand_sequencer
// Operator-entry front end for the 4-bit combinational calculator. Two bouncy
// push buttons (enter, clear) are synchronized and debounced. Enter presses step
// an FSM that captures operand A, the operator code and operand B from the board
// switches. The FSM then registers the calculator's result one cycle after B is
// captured.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_sw[3:0]    operand switches (quasi-static, sampled unsynchronized)
//   i_op[1:0]    operator switches: 00 add, 01 sub, 10 mul, 11 div
//   i_btn_enter  raw enter button, active-high, bouncy
//   i_btn_clear  raw clear button, active-high, bouncy
//   i_result     calculator result (combinational from o_a/o_b/o_select)
//   o_a, o_b     registered operands to calculator
//   o_select     registered operator code to calculator
//   o_result     registered captured result
//   o_state      current FSM state encoding
//   o_done       one-cycle pulse when o_result is updated
//   o_div_zero   divide-by-zero flag, set together with o_done
//
// state  | meaning
// S_A    | waiting for enter to capture operand A
// S_OP   | waiting for enter to capture operator code
// S_B    | waiting for enter to capture operand B
// S_CALC | one cycle: capture calculator result, pulse done
// S_SHOW | result displayed; enter starts a new entry
module calc_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_sw,
  input  logic [1:0] i_op,
  input  logic       i_btn_enter,
  input  logic       i_btn_clear,
  input  logic [3:0] i_result,
  output logic [3:0] o_a,
  output logic [3:0] o_b,
  output logic [1:0] o_select,
  output logic [3:0] o_result,
  output logic [2:0] o_state,
  output logic       o_done,
  output logic       o_div_zero
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_CALC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  // Bit 0 = enter, bit 1 = clear.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    db;
  logic [1:0]    db_q;
  logic [CW-1:0] cnt [2];
  logic          enter_ev;
  logic          clear_ev;
  state_t        state;

  assign raw = {i_btn_clear, i_btn_enter};

  // The counter only runs while the synchronized level disagrees with the
  // debounced level; it toggles the debounced level on the last count and
  // never needs to reach DEBOUNCE_CYCLES itself.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i] <= '0;
          db[i]  <= ~db[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Rising edge of the debounced level; releases produce nothing.
  assign enter_ev = db[0] & ~db_q[0];
  assign clear_ev = db[1] & ~db_q[1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= S_A;
      o_a        <= '0;
      o_b        <= '0;
      o_select   <= '0;
      o_result   <= '0;
      o_done     <= 1'b0;
      o_div_zero <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (clear_ev) begin
        // Clear beats a coincident enter.
        state      <= S_A;
        o_a        <= '0;
        o_b        <= '0;
        o_select   <= '0;
        o_result   <= '0;
        o_div_zero <= 1'b0;
      end else begin
        case (state)
          S_A: begin
            if (enter_ev) begin
              o_a   <= i_sw;
              state <= S_OP;
            end
          end
          S_OP: begin
            if (enter_ev) begin
              o_select <= i_op;
              state    <= S_B;
            end
          end
          S_B: begin
            if (enter_ev) begin
              o_b   <= i_sw;
              state <= S_CALC;
            end
          end
          S_CALC: begin
            o_result   <= i_result;
            o_done     <= 1'b1;
            o_div_zero <= (o_select == 2'b11) && (o_b == 4'd0);
            state      <= S_SHOW;
          end
          S_SHOW: begin
            if (enter_ev) state <= S_A;
          end
          default: state <= S_A;
        endcase
      end
    end
  end

  assign o_state = state;

endmodule
